// File: rtl/inst_cache_if.sv
// CPU fetch port and instruction-memory word port of the instruction cache.
// The slave view belongs to the cache; the master view belongs to the pipeline and memory side.
interface inst_cache_if;
  logic        cpu_ren;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data;
  logic        cpu_stall;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_ack;

  modport slave  (input  cpu_ren, cpu_addr, flush, mem_din, mem_ack,
                  output cpu_data, cpu_stall, mem_req, mem_addr);
  modport master (output cpu_ren, cpu_addr, flush, mem_din, mem_ack,
                  input  cpu_data, cpu_stall, mem_req, mem_addr);
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hits, stall-and-refill on miss,
// one word per memory req/ack, with whole-cache flush.
module inst_cache #(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  inst_cache_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [31:0]        r_data [LINES*LINE_WORDS];
  logic [TAG_W-1:0]   r_miss_tag;
  logic [IDX_W-1:0]   r_miss_idx;
  logic [OFF_W-1:0]   r_cnt;
  logic               r_flush_pend;

  logic [TAG_W-1:0]   w_tag;
  logic [IDX_W-1:0]   w_idx;
  logic [OFF_W-1:0]   w_off;
  logic               w_hit;
  logic               w_last;

  assign w_tag  = bus.cpu_addr[31 -: TAG_W];
  assign w_idx  = bus.cpu_addr[IDX_W+OFF_W+1 : OFF_W+2];
  assign w_off  = bus.cpu_addr[OFF_W+1 : 2];
  assign w_hit  = bus.cpu_ren & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_last = (r_cnt == OFF_W'(LINE_WORDS-1));

  always_comb begin
    w_next        = r_state;
    bus.cpu_data  = '0;
    bus.cpu_stall = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_addr  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) bus.cpu_data = r_data[{w_idx, w_off}];
        bus.cpu_stall = bus.cpu_ren & ~w_hit;
        if (bus.cpu_ren && !w_hit) w_next = S_REFILL;
      end
      S_REFILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {r_miss_tag, r_miss_idx, r_cnt, 2'b00};
        if (bus.mem_ack && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        bus.cpu_stall = 1'b1;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset overrides everything, including an in-flight refill request.
    if (i_rst) begin
      w_next        = S_IDLE;
      bus.cpu_data  = '0;
      bus.cpu_stall = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_addr  = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_valid      <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.flush) r_valid <= '0;
          if (bus.cpu_ren && !w_hit) begin
            r_miss_tag <= w_tag;
            r_miss_idx <= w_idx;
            r_cnt      <= '0;
          end
        end
        S_REFILL: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          // Counter holds on the final word; it returns to zero on leaving S_DONE.
          if (bus.mem_ack && !w_last) r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          if (r_flush_pend || bus.flush) r_valid <= '0;
          else                           r_valid[r_miss_idx] <= 1'b1;
          r_flush_pend <= 1'b0;
          r_cnt        <= '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == S_REFILL && bus.mem_ack) r_data[{r_miss_idx, r_cnt}] <= bus.mem_din;
      if (r_state == S_DONE)                  r_tag[r_miss_idx] <= r_miss_tag;
    end
  end
endmodule

// File: tb/tb_inst_cache.sv
// Randomized scoreboard bench for inst_cache: a line-level cache model predicts hit/miss,
// stall length and refill addresses; a monitor and a memory responder check the DUT.
module tb_inst_cache;
  localparam int LINES = 16;
  localparam int LW    = 4;
  localparam int LB    = LW * 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_cache_if bus ();
  inst_cache #(.LINES(LINES), .LINE_WORDS(LW)) u_dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];
  logic [31:0] mem_q[$];
  bit          mon_en    = 1'b0;
  bit          force_ack = 1'b0;
  int          ack_dly   = 0;
  int          ack_seen  = 0;

  bit          m_valid [LINES];
  int unsigned m_tag   [LINES];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic push_refill(input logic [31:0] a);
    logic [31:0] base;
    base = (a / LB) * LB;
    for (int w = 0; w < LW; w++) mem_q.push_back(base + 32'(w * 4));
  endtask

  // Memory side: ack each word after ack_dly wait cycles; checks address order and stability.
  initial begin
    int          wcnt;
    logic [31:0] last_addr;
    logic [31:0] ea;
    wcnt = 0;
    last_addr = '0;
    bus.mem_ack = 1'b0;
    bus.mem_din = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (force_ack) begin
        bus.mem_ack = 1'b1;
        bus.mem_din = 32'hDEAD_BEEF;
      end else if (bus.mem_req) begin
        if (wcnt > 0) chk("mem_addr_stable", bus.mem_addr, last_addr);
        last_addr = bus.mem_addr;
        if (wcnt >= ack_dly) begin
          bus.mem_ack = 1'b1;
          bus.mem_din = mem_word(bus.mem_addr);
          wcnt = 0;
          ack_seen++;
          if (mem_q.size() == 0) fail("unexpected_mem_req");
          else begin
            ea = mem_q.pop_front();
            chk("mem_addr", bus.mem_addr, ea);
          end
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Monitor: counts stall cycles of each fetch and compares the returned word.
  initial begin
    int   stall_cnt;
    exp_t e;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) stall_cnt = 0;
      else if (!bus.cpu_ren) begin
        stall_cnt = 0;
        chk("idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
        chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("idle_data", bus.cpu_data, 32'd0);
      end else if (bus.cpu_stall) stall_cnt++;
      else begin
        if (sb_q.size() == 0) fail("unexpected_fetch_done");
        else begin
          e = sb_q.pop_front();
          chk("cpu_data", bus.cpu_data, e.data);
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
          chk("hit_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  // Fetch a; fl >= 0 requests a flush pulse fl cycles after the miss cycle (misses only).
  task automatic fetch(input logic [31:0] a, input int fl);
    int   idx, tg, m, k;
    bit   hit;
    exp_t e;
    idx = int'((a / LB) % LINES);
    tg  = int'(a / (LB * LINES));
    hit = m_valid[idx] && (m_tag[idx] == tg);
    m   = 2 + LW * (ack_dly + 1);
    if (hit) fl = -1;
    e.addr = a;
    e.data = mem_word((a / 4) * 4);
    if (hit) e.stalls = 0;
    else if (fl > 0) e.stalls = 32'(2 * m);
    else e.stalls = 32'(m);
    if (!hit) push_refill(a);
    if (fl > 0) push_refill(a);
    if (fl >= 0) model_clear();
    if (!hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.cpu_ren  = 1'b1;
    bus.cpu_addr = a;
    k = 0;
    forever begin
      bus.flush = (k == fl);
      @(negedge clk);
      if (!bus.cpu_stall) break;
      if (k > 1000) begin
        fail("fetch_timeout");
        break;
      end
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    bus.cpu_ren = 1'b0;
    bus.flush   = 1'b1;
    model_clear();
    @(posedge clk); #1;
    bus.flush = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    bus.cpu_ren = 1'b0;
    bus.flush   = 1'b0;
  endtask

  initial begin
    int          k, n0, r, fl;
    logic [31:0] a;
    model_clear();
    rst = 1'b1;
    bus.cpu_ren  = 1'b1;
    bus.cpu_addr = 32'h40;
    bus.flush    = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_stall", {31'd0, bus.cpu_stall}, 32'd0);
      chk("rst_data", bus.cpu_data, 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_ren = 1'b0;
    mon_en = 1'b1;

    // Cold miss, then line hits back-to-back, then conflict eviction.
    ack_dly = 0;
    fetch(32'h40, -1);
    fetch(32'h44, -1);
    fetch(32'h48, -1);
    fetch(32'h4C, -1);
    fetch(32'h40, -1);
    fetch(32'h140, -1);
    fetch(32'h40, -1);

    // Wait states on every word.
    ack_dly = 3;
    fetch(32'h208, -1);
    fetch(32'h20C, -1);
    ack_dly = 0;

    // Reset in the middle of a refill, then a stray ack while idle.
    @(posedge clk); #1;
    mon_en = 1'b0;
    push_refill(32'h300);
    bus.cpu_ren  = 1'b1;
    bus.cpu_addr = 32'h300;
    n0 = ack_seen;
    k = 0;
    while (ack_seen < n0 + 2 && k < 100) begin
      @(posedge clk);
      k++;
    end
    if (k >= 100) fail("reset_test_ack_timeout");
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("midrst_stall", {31'd0, bus.cpu_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_ren = 1'b0;
    mem_q.delete();
    model_clear();
    force_ack = 1'b1;
    @(negedge clk);
    chk("stray_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    @(negedge clk);
    chk("after_stray_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("after_stray_stall", {31'd0, bus.cpu_stall}, 32'd0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    fetch(32'h300, -1);
    fetch(32'h304, -1);

    // Flush in idle, flush during refill, flush coincident with a miss.
    do_flush();
    fetch(32'h44, -1);
    fetch(32'h500, 2);
    fetch(32'h504, -1);
    fetch(32'h600, 0);
    fetch(32'h604, -1);

    // Randomized traffic over a small footprint so hits, conflicts and flushes all occur.
    repeat (250) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) do_flush();
      else if (r < 8) idle_cycle();
      ack_dly = int'($urandom_range(0, 2));
      a = 32'(($urandom_range(0, 3) * LINES * LW + $urandom_range(0, 7) * LW
              + $urandom_range(0, LW - 1)) * 4) | 32'($urandom_range(0, 3));
      fl = -1;
      if (r >= 8 && r < 18) fl = int'($urandom_range(0, LW * (ack_dly + 1)));
      fetch(a, fl);
    end

    idle_cycle();
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    chk("mem_queue_empty", 32'(mem_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
